sync_fifo_128: RTL and testbench

- Single-clock synchronous FIFO; the storage end of the wen/ren/empty/full/rdata interface our FIFO tester drives.
- Writer pushes `wdata` with `wen`. Reader pops with `ren` and receives registered `rdata`.
- Adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between a data producer and a memory-side consumer running in the same clock domain.

---
 rtl/sync_fifo_128.sv | 105 ++++++++++
 tb/tb_sync_fifo_128.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_128.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags,
// sticky overflow/underflow errors and a synchronous flush.
module sync_fifo_128 #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              empty,
    output logic              full,
    output logic              afull,
    output logic              aempty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] ONE_C    = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_acc;
    logic              rd_acc;

    // Handshake: a write is taken when wen && !full, a read when ren && !empty,
    // both judged on this cycle's registered flags; clr overrides both requests.
    // Accepted reads return rdata with rvalid high exactly one cycle later.
    always_comb begin
        wr_acc    = wen && !full && !clr;
        rd_acc    = ren && !empty && !clr;
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + ONE_C;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - ONE_C;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ADDR_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            empty     <= 1'b1;
            full      <= 1'b0;
            afull     <= 1'b0;
            aempty    <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count  <= count_nxt;
            empty  <= (count_nxt == '0);
            full   <= (count_nxt == DEPTH_C);
            afull  <= (count_nxt >= AFULL_C);
            aempty <= (count_nxt <= AEMPTY_C);
            rvalid <= rd_acc;
            if (clr) begin
                wptr      <= '0;
                rptr      <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wptr <= wptr + ONE_C;
                end
                if (rd_acc) begin
                    rptr  <= rptr + ONE_C;
                    rdata <= mem[rptr[ADDR_W-1:0]];
                end
                if (wen && full) begin
                    overflow <= 1'b1;
                end
                if (ren && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_128.sv
// Directed bench for sync_fifo_128: a queue model of the FIFO feeds an expected
// read-data queue, and every cycle the outputs are compared against the model.
module tb_sync_fifo_128;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         wen;
    logic [127:0] wdata;
    logic         ren;
    logic [127:0] rdata;
    logic         rvalid;
    logic         empty;
    logic         full;
    logic         afull;
    logic         aempty;
    logic [4:0]   count;
    logic         overflow;
    logic         underflow;

    int checks = 0;
    int errors = 0;

    logic [127:0] mdl_q[$];
    logic [127:0] exp_q[$];
    bit           m_ovf;
    bit           m_unf;
    logic [127:0] last_rd;

    sync_fifo_128 dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wen      (wen),
        .wdata    (wdata),
        .ren      (ren),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .empty    (empty),
        .full     (full),
        .afull    (afull),
        .aempty   (aempty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = mdl_q.size();
        chk("count", 128'(count), 128'(sz));
        chk("empty", 128'(empty), 128'(sz == 0));
        chk("full", 128'(full), 128'(sz == 16));
        chk("afull", 128'(afull), 128'(sz >= 14));
        chk("aempty", 128'(aempty), 128'(sz <= 2));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        chk("underflow", 128'(underflow), 128'(m_unf));
    endtask

    task automatic model_reset();
        mdl_q.delete();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        last_rd = '0;
    endtask

    // driver: one clock cycle of stimulus, model update, then output checks
    task automatic step(input bit w, input logic [127:0] d, input bit r, input bit c);
        bit wacc;
        bit racc;
        int sz;
        sz    = mdl_q.size();
        wen   = w;
        wdata = d;
        ren   = r;
        clr   = c;
        wacc  = w && !c && (sz < 16);
        racc  = r && !c && (sz > 0);
        if (c) begin
            mdl_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && sz == 16) m_ovf = 1'b1;
            if (r && sz == 0)  m_unf = 1'b1;
        end
        if (racc) exp_q.push_back(mdl_q.pop_front());
        if (wacc) mdl_q.push_back(d);
        @(posedge clk);
        #1;
        chk("rvalid", 128'(rvalid), 128'(racc));
        if (racc) last_rd = exp_q.pop_front();
        chk("rdata", rdata, last_rd);
        check_state();
    endtask

    initial begin
        rst   = 1'b1;
        clr   = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = '0;
        model_reset();
        #1;
        chk("reset_rvalid", 128'(rvalid), 128'(0));
        chk("reset_rdata", rdata, 128'(0));
        check_state();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // fill to full with 0x1..0x10
        for (int i = 1; i <= 16; i++) step(1'b1, 128'(i), 1'b0, 1'b0);
        // write while full
        step(1'b1, 128'hDEAD, 1'b0, 1'b0);
        // drain 16 words, one idle cycle to see rvalid drop
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        // read while empty, then flush clears both sticky flags
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // hold count at 8 through 40 simultaneous write/read cycles
        for (int i = 0; i < 8; i++) step(1'b1, 128'(32'h100 + i), 1'b0, 1'b0);
        for (int i = 8; i < 48; i++) step(1'b1, 128'(32'h100 + i), 1'b1, 1'b0);

        // flush wins over concurrent requests
        step(1'b1, 128'h5555, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // simultaneous write/read while full
        for (int i = 0; i < 16; i++) step(1'b1, 128'(32'h200 + i), 1'b0, 1'b0);
        step(1'b1, 128'hBEEF, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        // simultaneous write/read while empty
        step(1'b1, 128'h77, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // async reset mid-burst with a read in flight
        for (int i = 0; i < 5; i++) step(1'b1, 128'(32'h300 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_rvalid", 128'(rvalid), 128'(0));
        chk("async_rst_rdata", rdata, 128'(0));
        check_state();
        ren = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        step(1'b1, 128'hABC, 1'b0, 1'b0);
        step(1'b1, 128'hABD, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("first_after_reset", rdata, 128'hABC);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
